// File: rtl/mux_nto1_arb.sv
// mux_nto1_arb: N:1 stream multiplexer with one registered output slot.
// mode=0 selects channels round-robin; mode=1 passes the channel named by sel.
// Each transfer costs one cycle of latency, and the mux can move one word
// per cycle.
// Optional feature macro: MUX_NTO1_SEL_ERR_EN adds a sticky 'err' output.
// 'err' is set by any cycle that has mode=1 and sel>=N.
module mux_nto1_arb #(
   parameter  int N    = 4,
   parameter  int W    = 8,
   localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_chan,
   output logic              out_valid,
   input  logic              out_ready
`ifdef MUX_NTO1_SEL_ERR_EN
   ,
   output logic              err
`endif
);

   // Pad the channel space up to 2**SELW entries.
   // Any sel value then indexes safely, and the unused slots read as idle.
   localparam int SELN = 1 << SELW;

   logic [SELN-1:0] valid_pad;
   logic [W-1:0]    chan_data [SELN];

   logic            accept;
   logic            sel_ok;
   logic            fix_found;
   logic            rr_found;
   logic            grant_exists;
   logic            xfer;
   logic [SELW-1:0] rr_grant;
   logic [SELW-1:0] grant;
   int              idx;

   logic [W-1:0]    out_data_q,  out_data_d;
   logic [SELW-1:0] out_chan_q,  out_chan_d;
   logic            out_valid_q, out_valid_d;
   logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

   assign valid_pad = SELN'(in_valid);

   generate
      for (genvar gi = 0; gi < SELN; gi++) begin : g_chan
         if (gi < N) begin : g_real
            assign chan_data[gi] = in_data[gi*W +: W];
         end else begin : g_pad
            assign chan_data[gi] = '0;
         end
      end
   endgenerate

   // The output slot can take a word when it is empty or is being drained this cycle.
   assign accept    = ~out_valid_q | out_ready;
   assign sel_ok    = ({1'b0, sel} < (SELW+1)'(N));
   assign fix_found = sel_ok & valid_pad[sel];

   // Round-robin scan: the nearest valid channel at or after rr_ptr wins.
   // The loop runs from far to near, so the closest hit is written last.
   always_comb begin
      rr_found = 1'b0;
      rr_grant = '0;
      idx      = 0;
      for (int k = N-1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (valid_pad[SELW'(idx)]) begin
            rr_found = 1'b1;
            rr_grant = SELW'(idx);
         end
      end
   end

   assign grant        = mode ? sel : rr_grant;
   assign grant_exists = mode ? fix_found : rr_found;
   assign xfer         = ~rst & accept & grant_exists;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ready
         assign in_ready[gi] = xfer & (grant == SELW'(gi));
      end
   endgenerate

   // Next state of the output slot and the round-robin pointer.
   // A stall holds every register.
   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_data_d  = chan_data[grant];
         out_chan_d  = grant;
         out_valid_d = 1'b1;
         if (!mode) begin
            rr_ptr_d = (int'(grant) == N-1) ? '0 : grant + SELW'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Register update.
   // Reset empties the slot and restarts the round-robin scan at channel 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

`ifdef MUX_NTO1_SEL_ERR_EN
   logic err_q;

   // Sticky flag for fixed-select cycles whose sel is out of range.
   // Only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (mode && !sel_ok) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Testbench for mux_nto1_arb (N=4, W=8).
// Stages, in order:
// - a table of hand-derived vectors
// - hand-written corner sequences
// - randomized traffic checked against a reference model
// - an extra N=6 instance when MUX_NTO1_SEL_ERR_EN is defined
module tb_mux_nto1_arb;

   logic        clk;
   logic        rst;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_chan;
   logic        out_valid;
   logic        out_ready;
`ifdef MUX_NTO1_SEL_ERR_EN
   logic        err4;
   logic        rst6, mode6, out_ready6, out_valid6, err6;
   logic [2:0]  sel6, out_chan6;
   logic [47:0] in_data6;
   logic [5:0]  in_valid6, in_ready6;
   logic [7:0]  out_data6;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state, at the level of the arbitration rules.
   logic        m_v;
   logic [7:0]  m_d;
   int          m_c;
   int          m_ptr;
   logic [3:0]  e_rdy;

   // Values sampled from the DUT in the most recent cycle.
   logic [3:0]  a_rdy;
   logic        a_v;
   logic [7:0]  a_d;
   logic [1:0]  a_c;

   typedef struct {
      logic       r;
      logic       m;
      logic [1:0] s;
      logic [3:0] v;
      logic       o;
      logic [3:0] rdy;
      logic       ov;
      logic [7:0] od;
      logic [1:0] oc;
   } vec_t;

   vec_t tbl [10];

   mux_nto1_arb #(.N(4), .W(8)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready)
`ifdef MUX_NTO1_SEL_ERR_EN
      , .err(err4)
`endif
   );

`ifdef MUX_NTO1_SEL_ERR_EN
   mux_nto1_arb #(.N(6), .W(8)) dut6 (
      .clk(clk), .rst(rst6), .mode(mode6), .sel(sel6),
      .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
      .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6),
      .out_ready(out_ready6), .err(err6)
   );
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // The winner is the nearest valid channel at or after the pointer.
   // Return -1 when nothing is valid.
   function automatic int ref_grant(input logic m, input logic [1:0] s, input logic [3:0] v);
      int i;
      if (m) return v[s] ? int'(s) : -1;
      for (int d = 0; d < 4; d++) begin
         i = (m_ptr + d) % 4;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // One clock cycle:
   // - drive the inputs after the falling edge
   // - sample in_ready
   // - step the model at the rising edge
   // - sample the outputs 1 time unit later
   task automatic cycle(input logic r, input logic m, input logic [1:0] s,
                        input logic [3:0] v, input logic o);
      int g;
      @(negedge clk);
      rst = r; mode = m; sel = s; in_valid = v; out_ready = o;
      #1;
      a_rdy = in_ready;
      g = ref_grant(m, s, v);
      e_rdy = (r || (m_v && !o) || g < 0) ? 4'b0000 : 4'(1 << g);
      @(posedge clk);
      if (r) begin
         m_v = 1'b0; m_d = 8'h00; m_c = 0; m_ptr = 0;
      end else if ((!m_v || o) && g >= 0) begin
         m_v = 1'b1;
         m_d = in_data[g*8 +: 8];
         m_c = g;
         if (!m) m_ptr = (g + 1) % 4;
      end else if (o) begin
         m_v = 1'b0;
      end
      #1;
      a_v = out_valid; a_d = out_data; a_c = out_chan;
      $display("cyc rst=%0b mode=%0b sel=%0d vld=%b ordy=%0b -> rdy=%b ov=%0b od=%h oc=%0d",
               r, m, s, v, o, a_rdy, a_v, a_d, a_c);
   endtask

   task automatic expect_out(input string nm, input logic [3:0] rdy, input logic ov,
                             input logic [7:0] od, input logic [1:0] oc);
      chk({nm, "_rdy"}, a_rdy, rdy);
      chk({nm, "_ov"}, a_v, ov);
      if (ov) begin
         chk({nm, "_od"}, a_d, od);
         chk({nm, "_oc"}, a_c, oc);
      end
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0; out_ready = 1'b0;
      in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      m_v = 1'b0; m_d = 8'h00; m_c = 0; m_ptr = 0; e_rdy = 4'b0;
`ifdef MUX_NTO1_SEL_ERR_EN
      rst6 = 1'b1; mode6 = 1'b0; sel6 = 3'd0; in_valid6 = 6'b0; out_ready6 = 1'b1;
      in_data6 = {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
`endif

      // Table rows: reset, round-robin 0..3,0, a three-cycle stall, then release.
      tbl[0] = '{1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
      tbl[1] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
      tbl[2] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
      tbl[3] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
      tbl[4] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
      tbl[5] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
      tbl[6] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
      tbl[7] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
      tbl[8] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
      tbl[9] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};

      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].r, tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].o);
         chk($sformatf("tbl%0d_rdy", i), a_rdy, tbl[i].rdy);
         chk($sformatf("tbl%0d_ov", i), a_v, tbl[i].ov);
         chk($sformatf("tbl%0d_od", i), a_d, tbl[i].od);
         chk($sformatf("tbl%0d_oc", i), a_c, tbl[i].oc);
      end

      // Fixed select of channel 2, then channel 2 goes idle.
      cycle(1'b1, 1'b1, 2'd2, 4'b1111, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 2'd2, 4'b1111, 1'b1);
         expect_out("fix2", 4'b0100, 1'b1, 8'hA2, 2'd2);
      end
      cycle(1'b0, 1'b1, 2'd2, 4'b1011, 1'b1);
      expect_out("fix2_idle", 4'b0000, 1'b0, 8'h00, 2'd0);

      // Sparse valids: channels 1 and 3 alternate.
      cycle(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 2'd0, 4'b1010, 1'b1);
         if (i % 2 == 0) expect_out("sparse", 4'b0010, 1'b1, 8'hA1, 2'd1);
         else            expect_out("sparse", 4'b1000, 1'b1, 8'hA3, 2'd3);
      end

      // Reset in mid-stream: the slot is emptied and the scan restarts at channel 0.
      cycle(1'b0, 1'b0, 2'd0, 4'b1111, 1'b1);
      cycle(1'b0, 1'b0, 2'd0, 4'b1111, 1'b0);
      cycle(1'b1, 1'b0, 2'd0, 4'b1111, 1'b0);
      expect_out("midrst", 4'b0000, 1'b0, 8'h00, 2'd0);
      chk("midrst_od0", a_d, 8'h00);
      chk("midrst_oc0", a_c, 2'd0);
      cycle(1'b0, 1'b0, 2'd0, 4'b1111, 1'b1);
      expect_out("midrst_first", 4'b0001, 1'b1, 8'hA0, 2'd0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         in_data = $urandom;
         cycle(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) == 0),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 3) != 0));
         chk("rnd_rdy", a_rdy, e_rdy);
         chk("rnd_ov", a_v, m_v);
         chk("rnd_od", a_d, m_d);
         chk("rnd_oc", a_c, m_c);
      end

`ifdef MUX_NTO1_SEL_ERR_EN
      // With N=4 the 2-bit sel never goes out of range.
      chk("err4_clear", err4, 0);
      // N=6: sel=5 is legal. sel=7 sets the sticky flag, and only reset clears it.
      @(negedge clk); rst6 = 1'b1; mode6 = 1'b1; sel6 = 3'd5; in_valid6 = 6'b111111;
      @(negedge clk); rst6 = 1'b0;
      @(posedge clk); #1;
      chk("n6_sel5_err", err6, 0);
      chk("n6_sel5_chan", out_chan6, 5);
      chk("n6_sel5_data", out_data6, 8'hA5);
      @(negedge clk); sel6 = 3'd7;
      #1 chk("n6_sel7_rdy", in_ready6, 0);
      @(posedge clk); #1;
      chk("n6_sel7_err", err6, 1);
      chk("n6_sel7_ov", out_valid6, 0);
      @(negedge clk); sel6 = 3'd0;
      @(posedge clk); #1;
      chk("n6_sticky", err6, 1);
      @(negedge clk); rst6 = 1'b1;
      @(posedge clk); #1;
      chk("n6_rst_clr", err6, 0);
      $display("err block done err6=%0b", err6);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
